// File: rtl/sym_decoder.sv
// sym_decoder: buffers 2-bit code words in a FIFO and presents each as a one-hot strobe.
// Define SYM_DEC_PARITY_EN to add odd-parity checking (in_par, par_err, err_cnt).
module sym_decoder #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [1:0]               in_code,
`ifdef SYM_DEC_PARITY_EN
   input  logic                     in_par,
   output logic                     par_err,
   output logic [CNT_W-1:0]         err_cnt,
`endif
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [3:0]               out_onehot,
   output logic [1:0]               out_code,
   output logic [$clog2(DEPTH):0]   level,
   output logic [CNT_W-1:0]         sym_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   logic [1:0]       mem_q [DEPTH];
   logic [1:0]       mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
   logic             acc, good, wr, rd;
`ifdef SYM_DEC_PARITY_EN
   logic             par_err_q, par_err_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   assign good    = ^{in_par, in_code};
   assign par_err = par_err_q;
   assign err_cnt = err_cnt_q;
`else
   assign good = 1'b1;
`endif
   assign in_ready   = level_q != LW'(DEPTH);
   assign out_valid  = level_q != '0;
   assign acc        = in_valid && in_ready;
   assign wr         = acc && good;
   assign rd         = out_valid && out_ready;
   assign out_code   = out_valid ? mem_q[rd_ptr_q] : 2'b00;
   assign out_onehot = out_valid ? 4'b0001 << out_code : 4'b0000;
   assign level      = level_q;
   assign sym_cnt    = sym_cnt_q;
   always_comb begin
      mem_d = mem_q;
      if (wr) mem_d[wr_ptr_q] = in_code;
      wr_ptr_d  = wr_ptr_q + AW'(wr);
      rd_ptr_d  = rd_ptr_q + AW'(rd);
      level_d   = level_q + LW'(wr) - LW'(rd);
      sym_cnt_d = (wr && sym_cnt_q != '1) ? sym_cnt_q + CNT_W'(1) : sym_cnt_q;
`ifdef SYM_DEC_PARITY_EN
      par_err_d = acc && !good;
      err_cnt_d = (par_err_d && err_cnt_q != '1) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
`endif
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q     <= '{default: '0};
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         sym_cnt_q <= '0;
`ifdef SYM_DEC_PARITY_EN
         par_err_q <= 1'b0;
         err_cnt_q <= '0;
`endif
      end else begin
         mem_q     <= mem_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         sym_cnt_q <= sym_cnt_d;
`ifdef SYM_DEC_PARITY_EN
         par_err_q <= par_err_d;
         err_cnt_q <= err_cnt_d;
`endif
      end
   end
endmodule

// File: tb/tb_sym_decoder.sv
// tb_sym_decoder: directed and random stimulus against a queue-based model of the decoder.
// Honours SYM_DEC_PARITY_EN when the design is built with it.
module tb_sym_decoder;
   localparam int DEPTH = 4;
   logic       clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
   logic [1:0] in_code = 2'b00;
   logic       in_ready, out_valid, in_ready2, out_valid2;
   logic [3:0] out_onehot, out_onehot2;
   logic [1:0] out_code, out_code2;
   logic [2:0] level, level2;
   logic [7:0] sym_cnt;
   logic [1:0] sym_cnt2;
`ifdef SYM_DEC_PARITY_EN
   logic       in_par = 1'b0, par_err, par_err2;
   logic [7:0] err_cnt;
   logic [1:0] err_cnt2;
`endif
   int checks = 0, errors = 0;
   int q[$];
   int cnt = 0, ecnt = 0;
   bit exp_perr = 0;

   sym_decoder #(.DEPTH(DEPTH), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
`ifdef SYM_DEC_PARITY_EN
      .in_par(in_par), .par_err(par_err), .err_cnt(err_cnt),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .out_onehot(out_onehot),
      .out_code(out_code), .level(level), .sym_cnt(sym_cnt));

   sym_decoder #(.DEPTH(DEPTH), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_code(in_code),
`ifdef SYM_DEC_PARITY_EN
      .in_par(in_par), .par_err(par_err2), .err_cnt(err_cnt2),
`endif
      .out_valid(out_valid2), .out_ready(out_ready), .out_onehot(out_onehot2),
      .out_code(out_code2), .level(level2), .sym_cnt(sym_cnt2));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // reference: a queue of accepted good codes plus plain counters
   always @(posedge clk or posedge rst) begin
      bit acc, good, pop;
      if (rst) begin
         q.delete();
         cnt = 0;
         ecnt = 0;
         exp_perr = 0;
      end else begin
         acc  = in_valid && q.size() < DEPTH;
         pop  = out_ready && q.size() > 0;
         good = 1;
`ifdef SYM_DEC_PARITY_EN
         good = ^{in_par, in_code};
`endif
         exp_perr = acc && !good;
         if (exp_perr) ecnt++;
         if (pop) void'(q.pop_front());
         if (acc && good) begin
            q.push_back(int'(in_code));
            cnt++;
         end
      end
   end

   always @(negedge clk) begin
      int h;
      h = q.size() > 0 ? q[0] : 0;
      chk("level", level, q.size());
      chk("out_valid", out_valid, q.size() != 0);
      chk("in_ready", in_ready, q.size() != DEPTH);
      chk("out_code", out_code, h);
      chk("out_onehot", out_onehot, q.size() != 0 ? (1 << h) : 0);
      chk("sym_cnt", sym_cnt, cnt > 255 ? 255 : cnt);
      chk("sym_cnt_sat", sym_cnt2, cnt > 3 ? 3 : cnt);
`ifdef SYM_DEC_PARITY_EN
      chk("par_err", par_err, exp_perr);
      chk("err_cnt", err_cnt, ecnt > 255 ? 255 : ecnt);
`endif
   end

   initial begin
      repeat (2) @(posedge clk);
      #2;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_level", level, 0);
      chk("rst_onehot", out_onehot, 4'b0000);
      rst = 1'b0;
      step();
      // two pushes, then drain in order
      in_valid = 1'b1; in_code = 2'b10;
      step();
      in_code = 2'b01;
      step();
      in_valid = 1'b0;
      chk("two_level", level, 2);
      chk("two_head", out_onehot, 4'b0100);
      out_ready = 1'b1;
      step();
      chk("two_next", out_onehot, 4'b0010);
      step();
      chk("two_empty", out_valid, 0);
      chk("two_cnt", sym_cnt, 2);
      out_ready = 1'b0;
      // fill to FULL and hold in_valid
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_code = 2'(i);
         step();
      end
      in_code = 2'b00;
      chk("full_ready", in_ready, 0);
      step();
      chk("full_level", level, 4);
      chk("full_cnt", sym_cnt, 6);
      chk("sat_cnt", sym_cnt2, 3);
      in_valid = 1'b0; out_ready = 1'b1;
      step();
      chk("pop_ready", in_ready, 1);
      chk("pop_head", out_onehot, 4'b0010);
      repeat (3) step();
      chk("drained", level, 0);
      // steady push+pop at level 2
      out_ready = 1'b0; in_valid = 1'b1;
      repeat (2) begin
         in_code = 2'($urandom_range(3));
         step();
      end
      out_ready = 1'b1;
      repeat (10) begin
         in_code = 2'($urandom_range(3));
         step();
         chk("stream_level", level, 2);
      end
      in_valid = 1'b0;
      repeat (2) step();
      // reset mid-burst at level 3
      out_ready = 1'b0; in_valid = 1'b1;
      repeat (3) step();
      in_valid = 1'b0;
      chk("burst_level", level, 3);
      rst = 1'b1;
      #1;
      chk("arst_level", level, 0);
      chk("arst_valid", out_valid, 0);
      chk("arst_onehot", out_onehot, 4'b0000);
      chk("arst_ready", in_ready, 1);
      chk("arst_cnt", sym_cnt, 0);
      step();
      rst = 1'b0;
      step();
`ifdef SYM_DEC_PARITY_EN
      in_valid = 1'b1; in_code = 2'b11; in_par = 1'b0;
      step();
      in_valid = 1'b0;
      chk("bad_perr", par_err, 1);
      chk("bad_ecnt", err_cnt, 1);
      chk("bad_level", level, 0);
      step();
      chk("bad_perr_clr", par_err, 0);
      in_valid = 1'b1; in_par = 1'b1;
      step();
      in_valid = 1'b0;
      chk("good_onehot", out_onehot, 4'b1000);
      chk("good_level", level, 1);
      out_ready = 1'b1;
      step();
`endif
      // random traffic
      repeat (3000) begin
         in_valid  = ($urandom_range(3) != 0);
         out_ready = ($urandom_range(3) != 0) ? ($urandom_range(1) == 1) : 1'b0;
         in_code   = 2'($urandom_range(3));
`ifdef SYM_DEC_PARITY_EN
         in_par    = 1'($urandom_range(1));
`endif
         step();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (6) step();
      chk("final_level", level, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
